// File: rtl/fa_serial_ctrl_pkg.sv
// Shared constants and types for the nibble-serial adder sequencer.
package fa_serial_ctrl_pkg;
  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // One nibble's worth of work handed to the adder slice
  typedef struct packed {
    logic [NIBBLE_W-1:0] a;
    logic [NIBBLE_W-1:0] b;
    logic                ci;
  } fa_req_t;

  typedef struct packed {
    logic [NIBBLE_W-1:0] s;
    logic                co;
  } fa_rsp_t;
endpackage

// File: rtl/fa_4bit.sv
// 4-bit ripple-carry full adder slice; purely combinational.
module fa_4bit
  import fa_serial_ctrl_pkg::*;
(
  input  fa_req_t req,
  output fa_rsp_t rsp
);
  logic [NIBBLE_W:0] c;

  assign c[0] = req.ci;

  // Bit-level ripple chain
  for (genvar i = 0; i < NIBBLE_W; i++) begin : g_bit
    assign rsp.s[i] = req.a[i] ^ req.b[i] ^ c[i];
    assign c[i+1]   = (req.a[i] & req.b[i]) | (c[i] & (req.a[i] ^ req.b[i]));
  end

  assign rsp.co = c[NIBBLE_W];
endmodule

// File: rtl/fa_serial_ctrl.sv
// Sequencer that walks a WIDTH-bit add/sub through one 4-bit adder, LSB nibble first.
module fa_serial_ctrl
  import fa_serial_ctrl_pkg::*;
#(
  parameter int NIBBLES = 4,
  localparam int WIDTH  = NIBBLE_W * NIBBLES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDXW-1:0] LAST = IDXW'(NIBBLES - 1);

  state_t state, state_nx;

  logic [NIBBLES-1:0][NIBBLE_W-1:0] op_a, op_b, sum_r;
  logic [IDXW-1:0]                  idx;
  logic                             carry;
  logic                             last;
  fa_req_t                          fa_req;
  fa_rsp_t                          fa_rsp;

  assign last = (idx == LAST);

  // Feed the adder from the nibble currently selected by idx
  always_comb begin
    fa_req    = '0;
    fa_req.a  = op_a[idx];
    fa_req.b  = op_b[idx];
    fa_req.ci = carry;
  end

  fa_4bit u_fa (
    .req (fa_req),
    .rsp (fa_rsp)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // Next-state logic; DONE always returns to IDLE so start there is ignored
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (start) state_nx = ST_RUN;
      ST_RUN:  if (last)  state_nx = ST_DONE;
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Operand capture, per-nibble result/carry update and final flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a  <= '0;
      op_b  <= '0;
      sum_r <= '0;
      idx   <= '0;
      carry <= 1'b0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          op_a  <= a;
          op_b  <= sub ? ~b : b;   // A-B computed as A + ~B + 1
          carry <= sub;
          idx   <= '0;
        end
        ST_RUN: begin
          sum_r[idx] <= fa_rsp.s;
          carry      <= fa_rsp.co;
          if (last) begin
            cout <= fa_rsp.co;
            // carry into MSB (a^b^s) differs from carry out -> overflow
            ovf  <= op_a[idx][NIBBLE_W-1] ^ op_b[idx][NIBBLE_W-1] ^ fa_rsp.s[NIBBLE_W-1] ^ fa_rsp.co;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);
  assign sum  = sum_r;
endmodule

// File: tb/tb_fa_serial_ctrl.sv
// Scoreboard bench for fa_serial_ctrl: directed vectors, monitor checks each done pulse.
module tb_fa_serial_ctrl;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         sub = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         busy, done, cout, ovf;
  logic [W-1:0] sum;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    int           acc;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  fa_serial_ctrl #(.NIBBLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pop one expectation per done pulse, check pulse width too
  initial begin
    logic prev_done;
    exp_t e;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (prev_done) chk("done_single_cycle", {31'b0, done}, 32'd0);
      if (done && !prev_done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("sum", {16'b0, sum}, {16'b0, e.sum});
          chk("cout", {31'b0, cout}, {31'b0, e.cout});
          chk("ovf", {31'b0, ovf}, {31'b0, e.ovf});
          chk("latency", cyc, e.acc + 4);
        end
      end
      prev_done = done;
    end
  end

  task automatic wait_idle();
    int n;
    for (n = 0; n < 50; n++) begin
      @(negedge clk);
      if (!busy) break;
    end
    if (n == 50) chk("wait_idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic push(input logic [W-1:0] es, input logic ec, input logic eo, input int acc);
    exp_t e;
    e.sum = es; e.cout = ec; e.ovf = eo; e.acc = acc;
    sb.push_back(e);
  endtask

  // Issue one operation from IDLE and queue its expected result
  task automatic do_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic isub,
                       input logic [W-1:0] es, input logic ec, input logic eo);
    wait_idle();
    a = ia; b = ib; sub = isub; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_accept", {31'b0, busy}, 32'd1);
    push(es, ec, eo, cyc);
  endtask

  initial begin
    int acc0;
    int n;
    // Reset state
    #12;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_sum", {16'b0, sum}, 32'd0);
    chk("rst_cout", {31'b0, cout}, 32'd0);
    chk("rst_ovf", {31'b0, ovf}, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Arithmetic vectors
    do_op(16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0);
    do_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    do_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    do_op(16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    do_op(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);

    // Start while busy and operand changes mid-RUN must not matter
    do_op(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);
    start = 1'b1; a = 16'hAAAA;
    @(posedge clk); #1;
    start = 1'b0; a = 16'hFFFF; b = 16'hFFFF; sub = 1'b1;
    wait_idle();
    repeat (8) @(negedge clk);
    chk("no_extra_op", {31'b0, busy}, 32'd0);

    // Held start: back-to-back, second accepted at E6 with operands present then
    wait_idle();
    a = 16'h1111; b = 16'h2222; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    acc0 = cyc;
    push(16'h3333, 1'b0, 1'b0, acc0);
    a = 16'h4000; b = 16'h4000;
    repeat (6) @(posedge clk);
    #1;
    chk("second_accept_busy", {31'b0, busy}, 32'd1);
    push(16'h8000, 1'b0, 1'b1, acc0 + 6);
    start = 1'b0;

    // Async reset during the second RUN cycle
    wait_idle();
    do_op(16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    sb.delete();
    chk("arst_busy", {31'b0, busy}, 32'd0);
    chk("arst_done", {31'b0, done}, 32'd0);
    chk("arst_sum", {16'b0, sum}, 32'd0);
    chk("arst_cout", {31'b0, cout}, 32'd0);
    chk("arst_ovf", {31'b0, ovf}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    do_op(16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0);

    // Drain
    for (n = 0; n < 100; n++) begin
      @(negedge clk);
      if (sb.size() == 0) break;
    end
    if (n == 100) chk("drain_timeout", 32'd1, 32'd0);
    repeat (4) @(negedge clk);
    chk("sb_empty", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
